// File: rtl/rf_write_buffer_pkg.sv
// Shared widths and constants for the register-file write buffer slice.
package rf_write_buffer_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_fwd_match.sv
// Newest-first priority match of one read address against the buffered writes.
// Slot 0 of the input arrays is the newest entry, slot DEPTH-1 the oldest.
module rf_fwd_match
    import rf_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_IDX_W-1:0]             addr,
    input  logic [DEPTH-1:0]                 valid,
    input  logic [DEPTH-1:0][REG_IDX_W-1:0]  rd,
    input  logic [DEPTH-1:0][DATA_W-1:0]     data,
    output logic                             hit,
    output logic [DATA_W-1:0]                hit_data
);

    // Walk oldest to newest so a later (newer) match overrides an older one; R0 never matches.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (rd[i] == addr) && (addr != REG_ZERO)) begin
                hit      = 1'b1;
                hit_data = data[i];
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// In-order write buffer feeding the register file's single write port,
// with newest-value forwarding for the two read addresses.
module rf_write_buffer
    import rf_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [REG_IDX_W-1:0]  IN_RD,
    input  logic [DATA_W-1:0]     IN_DATA,
    input  logic                  WP_BUSY,
    output logic [REG_IDX_W-1:0]  RW,
    output logic [DATA_W-1:0]     PW,
    output logic                  LE,
    input  logic [REG_IDX_W-1:0]  RA,
    input  logic [REG_IDX_W-1:0]  RB,
    output logic                  FA_HIT,
    output logic [DATA_W-1:0]     FA_DATA,
    output logic                  FB_HIT,
    output logic [DATA_W-1:0]     FB_DATA,
    output logic [AW:0]           COUNT,
    output logic                  EMPTY
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]          head;
    logic [AW-1:0]          tail;
    logic [AW:0]            count;
    logic [REG_IDX_W-1:0]   rd_mem   [DEPTH];
    logic [DATA_W-1:0]      data_mem [DEPTH];
    logic                   push;
    logic                   pop;

    logic [DEPTH-1:0]                 age_valid;
    logic [DEPTH-1:0][REG_IDX_W-1:0]  age_rd;
    logic [DEPTH-1:0][DATA_W-1:0]     age_data;

    assign IN_READY = (count < FULL_COUNT);
    assign EMPTY    = (count == '0);
    assign COUNT    = count;

    // R0 writes are acknowledged but never stored.
    assign push = IN_VALID && IN_READY && (IN_RD != REG_ZERO);

    // The register file captures the head entry on the same edge it is popped.
    assign LE  = !EMPTY && !WP_BUSY;
    assign pop = LE;
    assign RW  = LE ? rd_mem[head]   : REG_ZERO;
    assign PW  = LE ? data_mem[head] : '0;

    // Pointer and occupancy bookkeeping; reset overrides any push or pop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; only occupancy decides which slots are meaningful.
    always_ff @(posedge Clk) begin
        if (push) begin
            rd_mem[tail]   <= IN_RD;
            data_mem[tail] <= IN_DATA;
        end
    end

    // Present the entries newest-first so the matchers only need a fixed priority.
    always_comb begin
        age_valid = '0;
        age_rd    = '0;
        age_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_valid[i] = ((AW+1)'(i) < count);
            age_rd[i]    = rd_mem[AW'(tail - AW'(i + 1))];
            age_data[i]  = data_mem[AW'(tail - AW'(i + 1))];
        end
    end

    rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .addr     (RA),
        .valid    (age_valid),
        .rd       (age_rd),
        .data     (age_data),
        .hit      (FA_HIT),
        .hit_data (FA_DATA)
    );

    rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .addr     (RB),
        .valid    (age_valid),
        .rd       (age_rd),
        .data     (age_data),
        .hit      (FB_HIT),
        .hit_data (FB_DATA)
    );

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed self-checking bench for rf_write_buffer.
module tb_rf_write_buffer;

    logic        Clk;
    logic        Reset;
    logic        IN_VALID;
    logic        IN_READY;
    logic [4:0]  IN_RD;
    logic [31:0] IN_DATA;
    logic        WP_BUSY;
    logic [4:0]  RW;
    logic [31:0] PW;
    logic        LE;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic        FA_HIT;
    logic [31:0] FA_DATA;
    logic        FB_HIT;
    logic [31:0] FB_DATA;
    logic [2:0]  COUNT;
    logic        EMPTY;

    int checks = 0;
    int errors = 0;

    logic [4:0]  qrd[$];
    logic [31:0] qdata[$];
    int          nextIn;
    logic        expReady;

    rf_write_buffer #(.DEPTH(4), .AW(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_RD    (IN_RD),
        .IN_DATA  (IN_DATA),
        .WP_BUSY  (WP_BUSY),
        .RW       (RW),
        .PW       (PW),
        .LE       (LE),
        .RA       (RA),
        .RB       (RB),
        .FA_HIT   (FA_HIT),
        .FA_DATA  (FA_DATA),
        .FB_HIT   (FB_HIT),
        .FB_DATA  (FB_DATA),
        .COUNT    (COUNT),
        .EMPTY    (EMPTY)
    );

    // Free-running clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic busy);
        IN_VALID = v;
        IN_RD    = rd;
        IN_DATA  = d;
        WP_BUSY  = busy;
        #1;
    endtask

    initial begin
        Reset    = 1'b1;
        IN_VALID = 1'b0;
        IN_RD    = 5'd0;
        IN_DATA  = 32'd0;
        WP_BUSY  = 1'b0;
        RA       = 5'd0;
        RB       = 5'd0;
        tick;
        tick;
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0);

        // Reset state
        checkOutput("rst_le",      LE,       0);
        checkOutput("rst_rw",      RW,       0);
        checkOutput("rst_pw",      PW,       0);
        checkOutput("rst_fa_hit",  FA_HIT,   0);
        checkOutput("rst_fb_hit",  FB_HIT,   0);
        checkOutput("rst_fa_data", FA_DATA,  0);
        checkOutput("rst_ready",   IN_READY, 1);
        checkOutput("rst_empty",   EMPTY,    1);
        checkOutput("rst_count",   COUNT,    0);

        // Single write drains the following cycle and still forwards while retiring
        applyStimulus(1, 3, 20, 0);
        checkOutput("t1_ready", IN_READY, 1);
        checkOutput("t1_le_pre", LE, 0);
        tick;
        RA = 5'd3;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_le",     LE,      1);
        checkOutput("t1_rw",     RW,      3);
        checkOutput("t1_pw",     PW,      20);
        checkOutput("t1_count",  COUNT,   1);
        checkOutput("t1_fa_hit", FA_HIT,  1);
        checkOutput("t1_fa_dat", FA_DATA, 20);
        tick;
        checkOutput("t1_empty",  EMPTY,  1);
        checkOutput("t1_le_post", LE,    0);
        checkOutput("t1_fa_gone", FA_HIT, 0);
        RA = 5'd0;

        // Fill while the port is busy, hold a fifth push, then drain in order
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 5'(k), 32'(20 + k), 1);
            tick;
        end
        applyStimulus(1, 7, 77, 1);
        checkOutput("t2_count_full", COUNT,    4);
        checkOutput("t2_ready_full", IN_READY, 0);
        checkOutput("t2_le_busy",    LE,       0);
        checkOutput("t2_rw_busy",    RW,       0);
        tick;
        checkOutput("t2_count_held", COUNT, 4);
        applyStimulus(1, 7, 77, 0);
        checkOutput("t2_le1",    LE,       1);
        checkOutput("t2_rw1",    RW,       1);
        checkOutput("t2_pw1",    PW,       21);
        checkOutput("t2_ready1", IN_READY, 0);
        tick;
        checkOutput("t2_rw2",    RW,       2);
        checkOutput("t2_pw2",    PW,       22);
        checkOutput("t2_ready2", IN_READY, 1);
        checkOutput("t2_count2", COUNT,    3);
        tick;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_rw3",    RW,    3);
        checkOutput("t2_pw3",    PW,    23);
        checkOutput("t2_count3", COUNT, 3);
        tick;
        checkOutput("t2_rw4",    RW,    4);
        checkOutput("t2_pw4",    PW,    24);
        checkOutput("t2_count4", COUNT, 2);
        tick;
        checkOutput("t2_rw5",    RW,    7);
        checkOutput("t2_pw5",    PW,    77);
        checkOutput("t2_count5", COUNT, 1);
        tick;
        checkOutput("t2_empty",  EMPTY, 1);
        checkOutput("t2_le_end", LE,    0);

        // Two writes to the same register: forward the newer one, retire in order
        applyStimulus(1, 5, 55, 1);
        tick;
        applyStimulus(1, 5, 56, 1);
        tick;
        RA = 5'd5;
        RB = 5'd6;
        applyStimulus(0, 0, 0, 1);
        checkOutput("t3_fa_hit", FA_HIT,  1);
        checkOutput("t3_fa_dat", FA_DATA, 56);
        checkOutput("t3_fb_hit", FB_HIT,  0);
        checkOutput("t3_fb_dat", FB_DATA, 0);
        RB = 5'd5;
        applyStimulus(0, 0, 0, 1);
        checkOutput("t3_fb_hit5", FB_HIT,  1);
        checkOutput("t3_fb_dat5", FB_DATA, 56);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_rw1",    RW,      5);
        checkOutput("t3_pw1",    PW,      55);
        checkOutput("t3_fa_d1",  FA_DATA, 56);
        tick;
        checkOutput("t3_rw2",    RW,      5);
        checkOutput("t3_pw2",    PW,      56);
        checkOutput("t3_fa_d2",  FA_DATA, 56);
        tick;
        checkOutput("t3_empty",  EMPTY,  1);
        checkOutput("t3_fa_end", FA_HIT, 0);
        RA = 5'd0;
        RB = 5'd0;

        // R0 writes are accepted and dropped, and R0 never forwards
        applyStimulus(1, 0, 99, 0);
        checkOutput("t4_ready",  IN_READY, 1);
        checkOutput("t4_fa_hit", FA_HIT,   0);
        tick;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_count", COUNT, 0);
        checkOutput("t4_le",    LE,    0);
        checkOutput("t4_empty", EMPTY, 1);
        tick;
        checkOutput("t4_le2",   LE,    0);

        // Full FIFO streaming with continuous input: pointers wrap, order kept
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 5'(8 + k), 32'(100 + k), 1);
            tick;
            qrd.push_back(5'(8 + k));
            qdata.push_back(32'(100 + k));
        end
        nextIn = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, 5'(12 + nextIn), 32'(104 + nextIn), 0);
            expReady = (qrd.size() < 4);
            checkOutput("t5_ready", IN_READY, expReady);
            checkOutput("t5_count", COUNT, 32'(qrd.size()));
            checkOutput("t5_le",    LE, qrd.size() != 0);
            if (qrd.size() != 0) begin
                checkOutput("t5_rw", RW, qrd[0]);
                checkOutput("t5_pw", PW, qdata[0]);
            end
            tick;
            if (qrd.size() != 0) begin
                void'(qrd.pop_front());
                void'(qdata.pop_front());
            end
            if (expReady) begin
                qrd.push_back(5'(12 + nextIn));
                qdata.push_back(32'(104 + nextIn));
                nextIn++;
            end
        end
        applyStimulus(0, 0, 0, 0);
        for (int c = 0; c < 10 && qrd.size() != 0; c++) begin
            checkOutput("t5_drain_rw", RW, qrd[0]);
            checkOutput("t5_drain_pw", PW, qdata[0]);
            tick;
            void'(qrd.pop_front());
            void'(qdata.pop_front());
        end
        checkOutput("t5_empty", EMPTY, 1);
        checkOutput("t5_le_end", LE, 0);

        // Reset with three entries pending discards them and the push in the reset cycle
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 5'(k), 32'(30 + k), 1);
            tick;
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("t6_count3", COUNT, 3);
        Reset = 1'b1;
        applyStimulus(1, 9, 99, 1);
        tick;
        Reset = 1'b0;
        RA = 5'd1;
        RB = 5'd9;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6_count", COUNT,    0);
        checkOutput("t6_le",    LE,       0);
        checkOutput("t6_fa",    FA_HIT,   0);
        checkOutput("t6_fb",    FB_HIT,   0);
        checkOutput("t6_ready", IN_READY, 1);
        checkOutput("t6_empty", EMPTY,    1);
        tick;
        checkOutput("t6_le2",    LE,    0);
        checkOutput("t6_count2", COUNT, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
